// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: front-end sequencing for the five-stage pipeline.
// It decides each cycle whether PC and IF/ID advance, hold or flush, and
// whether a bubble enters ID/EX. It covers load-use and branch-operand
// hazards, taken-branch flushes, memory-busy freezes and halt parking.
// Optional feature macro: HAZARD_STALL_COUNTER_EN builds the saturating
// stall-cycle counter. Without it, StallCycles is tied to zero.
module hazard_stall_controller #(
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] IDRs,
  input  logic [REG_BITS-1:0] IDRt,
  input  logic                IDUsesRs,
  input  logic                IDUsesRt,
  input  logic                IDIsBranchReg,
  input  logic                IDHlt,
  input  logic                BranchTaken,
  input  logic [REG_BITS-1:0] EXRd,
  input  logic                EXRegWrite,
  input  logic                EXMemRead,
  input  logic [REG_BITS-1:0] MEMRd,
  input  logic                MEMMemRead,
  input  logic                IMemBusy,
  input  logic                DMemBusy,
  output logic                PCWriteEnable,
  output logic                IFIDWriteEnable,
  output logic                IFIDNoop,
  output logic                IDEXNoop,
  output logic                Freeze,
  output logic                Halted,
  output logic [15:0]         StallCycles
);

  typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_stall_left;
  logic [1:0]  w_stall_left_next;

  logic        w_busy;
  logic        w_ex_match;
  logic        w_mem_match;
  logic [1:0]  w_need;

  assign w_busy = IMemBusy | DMemBusy;

  // R0 never carries a dependency since it is hard-wired to zero.
  assign w_ex_match = (EXRd != '0) &&
                      ((IDUsesRs && (IDRs == EXRd)) || (IDUsesRt && (IDRt == EXRd)));
  assign w_mem_match = (MEMRd != '0) &&
                       ((IDUsesRs && (IDRs == MEMRd)) || (IDUsesRt && (IDRt == MEMRd)));

  // Required bubble count for the instruction currently in ID.
  always_comb begin
    w_need = 2'd0;
    if (IDIsBranchReg) begin
      if (w_ex_match && EXMemRead) begin
        w_need = 2'd2;
      end else if (w_ex_match && EXRegWrite) begin
        w_need = 2'd1;
      end else if (w_mem_match && MEMMemRead) begin
        w_need = 2'd1;
      end
    end else if (w_ex_match && EXMemRead) begin
      w_need = 2'd1;
    end
  end

  // Next-state and output decode, in priority order rst > busy > halt > stall > flush.
  always_comb begin
    w_state_next      = r_state;
    w_stall_left_next = r_stall_left;
    PCWriteEnable     = 1'b1;
    IFIDWriteEnable   = 1'b1;
    IFIDNoop          = 1'b0;
    IDEXNoop          = 1'b0;
    Freeze            = 1'b0;
    Halted            = 1'b0;
    if (rst) begin
      w_state_next      = StRun;
      w_stall_left_next = 2'd0;
    end else if (w_busy) begin
      // Everything holds; the stall countdown resumes once memory is ready.
      PCWriteEnable   = 1'b0;
      IFIDWriteEnable = 1'b0;
      Freeze          = 1'b1;
      Halted          = (r_state == StHalt);
    end else if (r_state == StHalt) begin
      PCWriteEnable = 1'b0;
      IFIDNoop      = 1'b1;
      Halted        = 1'b1;
    end else if ((r_state == StStall) && (r_stall_left != 2'd0)) begin
      PCWriteEnable     = 1'b0;
      IFIDWriteEnable   = 1'b0;
      IDEXNoop          = 1'b1;
      w_stall_left_next = r_stall_left - 2'd1;
    end else if (w_need != 2'd0) begin
      // The first bubble is issued this cycle, so only N-1 remain.
      PCWriteEnable     = 1'b0;
      IFIDWriteEnable   = 1'b0;
      IDEXNoop          = 1'b1;
      w_state_next      = StStall;
      w_stall_left_next = w_need - 2'd1;
    end else if (IDHlt) begin
      w_state_next      = StHalt;
      w_stall_left_next = 2'd0;
    end else begin
      // Countdown exhausted and operands ready: advance, flushing on a taken branch.
      IFIDNoop          = BranchTaken;
      w_state_next      = StRun;
      w_stall_left_next = 2'd0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StRun;
      r_stall_left <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_stall_left <= w_stall_left_next;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] r_stall_cycles;

  // Count bubble and freeze cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
    end else if ((IDEXNoop || Freeze) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
`else
  assign StallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: a cycle-level model of the
// sequencing rules checked every cycle, plus directed literal expectations.
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  IDRs, IDRt, EXRd, MEMRd;
  logic        IDUsesRs, IDUsesRt, IDIsBranchReg, IDHlt, BranchTaken;
  logic        EXRegWrite, EXMemRead, MEMMemRead, IMemBusy, DMemBusy;
  logic        PCWriteEnable, IFIDWriteEnable, IFIDNoop, IDEXNoop, Freeze, Halted;
  logic [15:0] StallCycles;

  hazard_stall_controller #(.REG_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IDRs           (IDRs),
    .IDRt           (IDRt),
    .IDUsesRs       (IDUsesRs),
    .IDUsesRt       (IDUsesRt),
    .IDIsBranchReg  (IDIsBranchReg),
    .IDHlt          (IDHlt),
    .BranchTaken    (BranchTaken),
    .EXRd           (EXRd),
    .EXRegWrite     (EXRegWrite),
    .EXMemRead      (EXMemRead),
    .MEMRd          (MEMRd),
    .MEMMemRead     (MEMMemRead),
    .IMemBusy       (IMemBusy),
    .DMemBusy       (DMemBusy),
    .PCWriteEnable  (PCWriteEnable),
    .IFIDWriteEnable(IFIDWriteEnable),
    .IFIDNoop       (IFIDNoop),
    .IDEXNoop       (IDEXNoop),
    .Freeze         (Freeze),
    .Halted         (Halted),
    .StallCycles    (StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {PCWE, IFIDWE, IFIDNoop, IDEXNoop, Freeze, Halted}
  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] STL = 6'b000100;
  localparam logic [5:0] FRZ = 6'b000010;
  localparam logic [5:0] FLU = 6'b111000;
  localparam logic [5:0] HLT = 6'b011001;
  localparam logic [5:0] ALL = 6'b111111;

  int    checks = 0;
  int    errors = 0;
  logic  run_on = 1'b0;
  logic  lit_on = 1'b0;
  string lit_name = "";
  logic [5:0] lit_exp = '0;
  logic [5:0] lit_care = '0;
  logic  lit_cnt_on = 1'b0;
  logic [15:0] lit_cnt = '0;

  // Model state: halted flag, bubbles still owed, stall-cycle tally.
  int m_halt = 0;
  int m_owe  = 0;
  int m_cnt  = 0;

  function automatic logic dep(input logic [3:0] x);
    return (x != 4'd0) && ((IDUsesRs && IDRs == x) || (IDUsesRt && IDRt == x));
  endfunction

  function automatic int need();
    if (IDIsBranchReg) begin
      if (dep(EXRd) && EXMemRead) return 2;
      if (dep(EXRd) && EXRegWrite) return 1;
      if (dep(MEMRd) && MEMMemRead) return 1;
      return 0;
    end
    return (dep(EXRd) && EXMemRead) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  // Compare process: evaluates the model for the current inputs and checks every cycle.
  always @(negedge clk) begin
    if (run_on) begin
      logic [5:0] e;
      logic [5:0] got;
      logic [15:0] ecnt;
      int n;
      got = {PCWriteEnable, IFIDWriteEnable, IFIDNoop, IDEXNoop, Freeze, Halted};
`ifdef HAZARD_STALL_COUNTER_EN
      ecnt = m_cnt[15:0];
`else
      ecnt = 16'd0;
`endif
      chk("stall_cycles", StallCycles, ecnt);
      if (lit_cnt_on) chk({lit_name, "_cnt"}, StallCycles, lit_cnt);
      n = need();
      if (rst) begin
        e = DEF;
      end else if (IMemBusy || DMemBusy) begin
        e = {5'b00001, (m_halt != 0)};
      end else if (m_halt != 0) begin
        e = HLT;
      end else if (m_owe > 0) begin
        e = STL;
        m_owe = m_owe - 1;
      end else if (n > 0) begin
        e = STL;
        m_owe = n - 1;
      end else if (IDHlt) begin
        e = DEF;
        m_halt = 1;
      end else begin
        e = BranchTaken ? FLU : DEF;
      end
      chk("model_outputs", {10'd0, got}, {10'd0, e});
      if (lit_on) chk(lit_name, {10'd0, got & lit_care}, {10'd0, lit_exp & lit_care});
      if (rst) begin
        m_halt = 0;
        m_owe  = 0;
        m_cnt  = 0;
      end else if ((e[2] || e[1]) && m_cnt < 65535) begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic clr();
    {IDRs, IDRt, EXRd, MEMRd} = '0;
    {IDUsesRs, IDUsesRt, IDIsBranchReg, IDHlt, BranchTaken} = '0;
    {EXRegWrite, EXMemRead, MEMMemRead, IMemBusy, DMemBusy} = '0;
  endtask

  // One cycle with a literal expectation on the masked outputs.
  task automatic cyc(input string nm, input logic [5:0] exp, input logic [5:0] care);
    lit_name = nm;
    lit_exp  = exp;
    lit_care = care;
    lit_on   = 1'b1;
    @(posedge clk);
    #1;
    lit_on     = 1'b0;
    lit_cnt_on = 1'b0;
  endtask

  task automatic br_load5();
    clr();
    EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 4'd5;
    IDIsBranchReg = 1'b1; IDUsesRs = 1'b1; IDRs = 4'd5;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    #1 run_on = 1'b1;
    cyc("reset_0", DEF, ALL);
    cyc("reset_1", DEF, ALL);
    rst = 1'b0;
    cyc("idle", DEF, ALL);

    // Load-use: LW R3 in EX, ADD R?,R3 in ID.
    EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 4'd3; IDUsesRs = 1'b1; IDRs = 4'd3;
    cyc("lu_stall", STL, ALL);
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 4'd0; MEMMemRead = 1'b1; MEMRd = 4'd3;
    cyc("lu_resume", DEF, ALL);
    clr();
    cyc("lu_after", DEF, ALL);

    // BR after load: two bubbles then advance.
    br_load5();
    cyc("brl_stall1", STL, ALL);
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 4'd0; MEMMemRead = 1'b1; MEMRd = 4'd5;
    cyc("brl_stall2", STL, ALL);
    MEMMemRead = 1'b0; MEMRd = 4'd0;
    cyc("brl_resume", DEF, ALL);

    // BR after ALU write to Rt: one bubble.
    clr();
    IDIsBranchReg = 1'b1; IDUsesRt = 1'b1; IDRt = 4'd7; EXRegWrite = 1'b1; EXRd = 4'd7;
    cyc("bra_stall", STL, ALL);
    EXRegWrite = 1'b0; EXRd = 4'd0; MEMRd = 4'd7;
    cyc("bra_resume", DEF, ALL);

    // Taken branch flushes one slot.
    clr();
    BranchTaken = 1'b1;
    cyc("br_flush", FLU, ALL);
    clr();
    cyc("br_after", DEF, ALL);
    // R0 never matches.
    EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 4'd0; IDUsesRs = 1'b1; IDRs = 4'd0;
    BranchTaken = 1'b1;
    cyc("r0_flush", FLU, ALL);
    // Taken branch ignored while a stall is needed.
    clr();
    EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 4'd2; IDUsesRt = 1'b1; IDRt = 4'd2;
    BranchTaken = 1'b1;
    cyc("br_vs_stall", STL, ALL);
    clr();
    IMemBusy = 1'b1;
    cyc("imem_busy", FRZ, ALL);

    // Busy during the second cycle of an N=2 stall, counter restarted from reset.
    clr();
    rst = 1'b1;
    cyc("rst_pre_busy", DEF, ALL);
    rst = 1'b0;
    br_load5();
    cyc("busy_stall1", STL, ALL);
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 4'd0; MEMMemRead = 1'b1; MEMRd = 4'd5;
    DMemBusy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("busy_freeze", FRZ, ALL);
    DMemBusy = 1'b0;
    cyc("busy_stall2", STL, ALL);
    MEMMemRead = 1'b0; MEMRd = 4'd0;
    lit_cnt_on = 1'b1;
`ifdef HAZARD_STALL_COUNTER_EN
    lit_cnt = 16'd5;
`else
    lit_cnt = 16'd0;
`endif
    cyc("busy_resume", DEF, ALL);

    // Reset mid-stall abandons remaining bubbles.
    br_load5();
    cyc("rms_stall1", STL, ALL);
    EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 4'd0; MEMMemRead = 1'b1; MEMRd = 4'd5;
    rst = 1'b1;
    cyc("rms_reset", DEF, ALL);
    rst = 1'b0;
    clr();
    cyc("rms_after", DEF, ALL);

    // Halt: parks for ten cycles, ignores branches and hazards, exits only by reset.
    IDHlt = 1'b1;
    cyc("hlt_enter", DEF, ALL);
    clr();
    for (int i = 0; i < 10; i++) begin
      BranchTaken = i[0];
      EXMemRead = i[1]; EXRd = 4'd1; IDUsesRs = 1'b1; IDRs = 4'd1;
      cyc("hlt_park", HLT, ALL);
    end
    clr();
    DMemBusy = 1'b1;
    cyc("hlt_busy", 6'b000011, ALL);
    clr();
    rst = 1'b1;
    cyc("hlt_reset", DEF, ALL);
    rst = 1'b0;
    cyc("hlt_cleared", DEF, ALL);

    run_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
